mod_addsub_pipe: RTL and testbench
==================================

Name: mod_addsub_pipe

Overview:
- Parametrised, pipelined modular adder/subtractor: computes (a + b) mod q or (a − b) mod q for operands in [0, q).
- Range comparison and correction are folded into a registered second stage; the 2-bit range flags (raw ≥ 0, raw ≥ q) appear on the output.
- Valid/ready handshakes on input and output, so the block drops into streaming datapaths with backpressure.

Parameters:
- WIDTH, 5: operand and modulus width in bits. Unsigned operands; internal raw value is WIDTH+2 bits signed.
- QMIN, 2: smallest legal modulus. A smaller q flags range_err.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept a bundle this cycle
- op  input  1  0 = add, 1 = subtract (a − b)
- a  input  WIDTH  operand, expected 0 ≤ a < q
- b  input  WIDTH  operand, expected 0 ≤ b < q
- q  input  WIDTH  modulus, sampled together with the operands
- out_valid  output  1  result bundle valid
- out_ready  input  1  downstream accepts the result
- result  output  WIDTH  modular result
- flags  output  2  bit0 = raw ≥ 0; bit1 = raw ≥ q (signed compare, q zero-extended)
- range_err  output  1  a ≥ q, b ≥ q, or q < QMIN for this bundle
- corr_cnt  output  16  correction counter (see Optional Feature)

Behaviour:
- Reset (async, rst high): all pipeline valid bits, result, flags, range_err and corr_cnt clear to 0. in_ready is 0 while rst is high.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Inputs are ignored when no input transfer occurs.
- Stage S1 (registered on input transfer):
  - raw = a + b (op = 0) or a − b (op = 1), sign-extended to WIDTH+2 bits.
  - q, op and the range check are registered alongside raw.
- Stage S2 (registered on advance from S1):
  - flags[0] = raw ≥ 0; flags[1] = raw ≥ q.
  - result = raw + q if raw < 0; raw − q if raw ≥ q; raw otherwise. The value is truncated to WIDTH bits.
- range_err case: result and flags are still computed by the same rules. If q < QMIN, result is forced to 0 and flags to 2'b00.
- Latency: exactly 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 bundle per cycle.
- Stall rules:
  - S2 holds while out_valid && !out_ready.
  - S1 advances when S2 is empty or S2 is transferring this cycle.
  - in_ready = !S1_valid || S1 advances this cycle.
  - A full pipe with out_ready low holds 2 bundles; in_ready = 0.
- Simultaneous events:
  - Input transfer, S1→S2 advance and output transfer in the same cycle are all legal.
  - No bundle is lost or duplicated; output order equals input order.
- Output stability: result, flags and range_err stay stable while out_valid && !out_ready.
- Reset mid-operation: in-flight bundles are discarded; out_valid drops asynchronously.

Optional Feature:
- Macro: MOD_ADDSUB_CORR_CNT_EN.
- Defined:
  - corr_cnt counts output transfers whose result needed a correction (raw < 0 or raw ≥ q), excluding bundles with range_err.
  - The counter is 16-bit and saturates at 16'hFFFF.
  - It resets to 0.
- Undefined: corr_cnt is tied to 0 and no counter logic is present.

Test Plan:
- WIDTH=5, q=17, out_ready=1:
  - add 10+12 → result 5, flags 2'b11, out_valid exactly 2 cycles after acceptance.
  - sub 3−9 → result 11, flags 2'b00.
  - add 4+5 → result 9, flags 2'b01.
- Back-to-back stream: sub 0−0, add 16+16, sub 16−0 (q=17) → results 0, 15, 16 on consecutive cycles; in_ready stays 1.
- Backpressure: hold out_ready=0 and offer 3 bundles.
  - in_ready drops after 2 are accepted; the outputs hold stable.
  - On release, 3 results emerge in order with none lost.
- Range error: a=17, b=1, q=17 → range_err=1. With q=1 → result 0, flags 2'b00, range_err=1.
- Reset: assert rst with 2 bundles in flight → out_valid and in_ready go to 0 immediately. After release, a fresh add 1+1 (q=17) → result 2.
- With MOD_ADDSUB_CORR_CNT_EN: the stimulus above without the range errors → corr_cnt = 3 (22, −6, 32). Without the macro, corr_cnt = 0 throughout.

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor with valid/ready handshakes on both sides.
// Define MOD_ADDSUB_CORR_CNT_EN to enable the saturating correction counter on corr_cnt.
module mod_addsub_pipe #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned QMIN  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags,
    output logic             range_err,
    output logic [15:0]      corr_cnt
);

    localparam int unsigned RW = WIDTH + 2;
    localparam logic [WIDTH:0] QMIN_EXT = QMIN[WIDTH:0];

    // Handshake wires
    logic w_in_fire;
    logic w_s1_adv;
    logic w_out_fire;

    // Stage 1 input-side wires
    logic signed [RW-1:0] w_a_ext;
    logic signed [RW-1:0] w_b_ext;
    logic signed [RW-1:0] w_raw;
    logic                 w_q_bad;
    logic                 w_rerr;

    // Stage 1 registers
    logic                 r_s1_valid;
    logic signed [RW-1:0] r_s1_raw;
    logic [WIDTH-1:0]     r_s1_q;
    logic                 r_s1_rerr;
    logic                 r_s1_qbad;

    // Stage 2 next-value wires
    logic signed [RW-1:0] w_q_ext;
    logic                 w_neg;
    logic                 w_ge_q;
    logic signed [RW-1:0] w_fixed;
    logic [WIDTH-1:0]     w_s2_result;
    logic [1:0]           w_s2_flags;

    // Stage 2 registers
    logic                 r_s2_valid;
    logic [WIDTH-1:0]     r_result;
    logic [1:0]           r_flags;
    logic                 r_range_err;

    // ------------------------------------------------------------------
    // Handshake and stall control
    // ------------------------------------------------------------------
    assign w_out_fire = r_s2_valid && out_ready;
    assign w_s1_adv   = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready   = !rst && (!r_s1_valid || w_s1_adv);
    assign w_in_fire  = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: raw sum/difference and operand range check
    // ------------------------------------------------------------------
    assign w_a_ext = signed'({2'b00, a});
    assign w_b_ext = signed'({2'b00, b});

    always_comb begin
        if (op) begin
            w_raw = w_a_ext - w_b_ext;
        end else begin
            w_raw = w_a_ext + w_b_ext;
        end
    end

    assign w_q_bad = ({1'b0, q} < QMIN_EXT);
    assign w_rerr  = (a >= q) || (b >= q) || w_q_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_q     <= '0;
            r_s1_rerr  <= 1'b0;
            r_s1_qbad  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_raw   <= w_raw;
                r_s1_q     <= q;
                r_s1_rerr  <= w_rerr;
                r_s1_qbad  <= w_q_bad;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: range compare and single-step correction
    // ------------------------------------------------------------------
    assign w_q_ext = signed'({2'b00, r_s1_q});
    assign w_neg   = r_s1_raw[RW-1];
    assign w_ge_q  = (r_s1_raw >= w_q_ext);

    always_comb begin
        w_fixed = r_s1_raw;
        if (w_neg) begin
            w_fixed = r_s1_raw + w_q_ext;
        end else if (w_ge_q) begin
            w_fixed = r_s1_raw - w_q_ext;
        end
    end

    // A modulus below QMIN has no meaningful residue, so the result is forced to zero.
    always_comb begin
        w_s2_result = w_fixed[WIDTH-1:0];
        w_s2_flags  = {w_ge_q, !w_neg};
        if (r_s1_qbad) begin
            w_s2_result = '0;
            w_s2_flags  = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_result    <= '0;
            r_flags     <= 2'b00;
            r_range_err <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid  <= 1'b1;
                r_result    <= w_s2_result;
                r_flags     <= w_s2_flags;
                r_range_err <= r_s1_rerr;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign range_err = r_range_err;

    // ------------------------------------------------------------------
    // Optional correction counter
    // ------------------------------------------------------------------
`ifdef MOD_ADDSUB_CORR_CNT_EN
    logic        r_s2_corr;
    logic [15:0] r_corr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_corr <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_corr <= (w_neg || w_ge_q) && !r_s1_rerr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr_cnt <= '0;
        end else if (w_out_fire && r_s2_corr && (r_corr_cnt != 16'hFFFF)) begin
            r_corr_cnt <= r_corr_cnt + 16'd1;
        end
    end

    assign corr_cnt = r_corr_cnt;
`else
    assign corr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench for mod_addsub_pipe: directed cases, backpressure, reset, then random traffic.
module tb_mod_addsub_pipe;

    localparam int W    = 5;
    localparam int QMIN = 2;

    typedef struct {
        int res;
        int flg;
        int rerr;
        bit corr;
        int cyc;
        bit chk_lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] q = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [1:0]   flags;
    logic         range_err;
    logic [15:0]  corr_cnt;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    bit   rand_ready = 0;
    exp_t sb[$];

    mod_addsub_pipe #(.WIDTH(W), .QMIN(QMIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .range_err (range_err),
        .corr_cnt  (corr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer modular arithmetic.
    function automatic exp_t model(input bit mop, input int ma, input int mb, input int mq);
        exp_t e;
        int   raw;
        int   r;
        raw    = mop ? (ma - mb) : (ma + mb);
        e.rerr = ((ma >= mq) || (mb >= mq) || (mq < QMIN)) ? 1 : 0;
        if (mq < QMIN) begin
            e.res  = 0;
            e.flg  = 0;
            e.corr = 0;
        end else begin
            e.flg = ((raw >= mq) ? 2 : 0) + ((raw >= 0) ? 1 : 0);
            if (raw < 0) r = raw + mq;
            else if (raw >= mq) r = raw - mq;
            else r = raw;
            e.res  = r & ((1 << W) - 1);
            e.corr = ((raw < 0) || (raw >= mq)) && (e.rerr == 0);
        end
        e.cyc     = 0;
        e.chk_lat = 0;
        return e;
    endfunction

    // Offer one bundle until accepted (bounded); push the expectation at acceptance.
    task automatic send(input bit sop, input int sa, input int sb_, input int sq,
                        input bit lat, input bit must_be_ready);
        exp_t e;
        bit   done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = sop;
            a  = sa[W-1:0];
            b  = sb_[W-1:0];
            q  = sq[W-1:0];
            #1;
            if (must_be_ready && i == 0) check("in_ready_stream", int'(in_ready), 1);
            if (in_ready) begin
                e         = model(sop, sa, sb_, sq);
                e.cyc     = cyc;
                e.chk_lat = lat;
                sb.push_back(e);
                done      = 1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: compares the head of the scoreboard against whatever the DUT presents.
    initial begin
        bit   hold = 0;
        bit   seen = 0;
        int   h_res = 0;
        int   h_flg = 0;
        int   h_err = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 0;
                seen = 0;
            end else begin
                check("corr_cnt", int'(corr_cnt), model_cnt);
                if (hold && out_valid) begin
                    check("stable_result", int'(result), h_res);
                    check("stable_flags", int'(flags), h_flg);
                    check("stable_range_err", int'(range_err), h_err);
                end
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = sb[0];
                        if (!seen) begin
                            check("result", int'(result), e.res);
                            check("flags", int'(flags), e.flg);
                            check("range_err", int'(range_err), e.rerr);
                            if (e.chk_lat) check("latency", cyc - e.cyc, 2);
                            seen = 1;
                        end
                        if (out_ready) begin
                            void'(sb.pop_front());
                            seen = 0;
`ifdef MOD_ADDSUB_CORR_CNT_EN
                            if (e.corr && model_cnt < 65535) model_cnt = model_cnt + 1;
`endif
                        end
                    end
                end
                hold  = out_valid && !out_ready;
                h_res = int'(result);
                h_flg = int'(flags);
                h_err = int'(range_err);
            end
        end
    end

    initial begin
        int rq;
        int ra;
        int rb;
        // Reset state
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_result", int'(result), 0);
        check("rst_flags", int'(flags), 0);
        check("rst_range_err", int'(range_err), 0);
        check("rst_corr_cnt", int'(corr_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed, no backpressure
        send(0, 10, 12, 17, 1, 0);
        idle();
        send(1, 3, 9, 17, 1, 0);
        idle();
        send(0, 4, 5, 17, 1, 0);
        idle();
        repeat (3) @(negedge clk);

        // Back-to-back stream
        send(1, 0, 0, 17, 1, 1);
        send(0, 16, 16, 17, 1, 1);
        send(1, 16, 0, 17, 1, 1);
        idle();
        repeat (3) @(negedge clk);

        // Backpressure: two fill the pipe, third must wait
        out_ready = 1'b0;
        send(0, 1, 2, 17, 0, 0);
        send(1, 2, 5, 17, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = 1'b0;
            a  = 5'd7;
            b  = 5'd13;
            q  = 5'd17;
            #1;
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", int'(in_ready), 1);
        if (in_ready) sb.push_back(model(0, 7, 13, 17));
        idle();
        repeat (4) @(negedge clk);
        check("bp_drained", sb.size(), 0);

        // Range errors
        send(0, 17, 1, 17, 1, 0);
        send(0, 0, 0, 1, 1, 0);
        idle();
        repeat (3) @(negedge clk);

        // Reset with two bundles in flight
        out_ready = 1'b0;
        send(0, 3, 3, 17, 0, 0);
        send(0, 4, 4, 17, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_corr_cnt", int'(corr_cnt), 0);
        sb.delete();
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(0, 1, 1, 17, 1, 0);
        idle();
        repeat (3) @(negedge clk);

        // Random traffic with random backpressure
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) rq = $urandom_range(0, 31);
            else rq = $urandom_range(QMIN, 31);
            if (rq == 0 || $urandom_range(0, 9) == 0) begin
                ra = $urandom_range(0, 31);
                rb = $urandom_range(0, 31);
            end else begin
                ra = $urandom_range(0, rq - 1);
                rb = $urandom_range(0, rq - 1);
            end
            send(1'($urandom_range(0, 1)), ra, rb, rq, 0, 0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        @(negedge clk);
        rand_ready = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("final_drained", sb.size(), 0);
        check("final_out_valid", int'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
